// File: rtl/image_pkg.sv
// Shared definitions for the VGA pixel stage.
//   mode_e      : quantiser mode encodings (truncate, threshold, dither, bars)
//   BAYER_4X4   : standard 4x4 ordered-dither thresholds, row-major
//   side_t      : per-pixel side band carried alongside the ROM latency
//   sync_idle() : inactive level of a sync given its active polarity
//   bayer_thr() : threshold lookup by (row[1:0], col[1:0])
package image_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC  = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_DITHER = 2'd2,
    MODE_BARS   = 2'd3
  } mode_e;

  // Index = {row[1:0], col[1:0]}; element 0 is the top-left threshold.
  localparam logic [0:15][3:0] BAYER_4X4 = {
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  typedef struct packed {
    logic       in_win;
    logic       de;
    logic       hs;
    logic       vs;
    logic [1:0] row;
    logic [1:0] col;
    logic [2:0] bar;
  } side_t;

  function automatic logic sync_idle(input logic pol);
    return ~pol;
  endfunction

  function automatic logic [3:0] bayer_thr(input logic [1:0] r, input logic [1:0] c);
    return BAYER_4X4[{r, c}];
  endfunction

endpackage

// File: rtl/bayer_quantiser.sv
// One colour channel of the quantiser: reduces IN_BITS to OUT_BITS by
// truncation, 50% threshold, 4x4 ordered dither or a constant bar level.
//   pixel_clk, reset_n : clock, async active-low reset
//   mode               : latched frame mode
//   pix                : channel value from ROM
//   row, col           : low screen coordinate bits aligned with pix
//   bar_on             : this channel's bit of the test-bar index
//   blank              : force output to 0 (blanking / outside window)
//   q_out              : registered quantised channel
module bayer_quantiser
  import image_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                pixel_clk,
  input  logic                reset_n,
  input  mode_e               mode,
  input  logic [IN_BITS-1:0]  pix,
  input  logic [1:0]          row,
  input  logic [1:0]          col,
  input  logic                bar_on,
  input  logic                blank,
  output logic [OUT_BITS-1:0] q_out
);

  localparam int PW = IN_BITS + OUT_BITS;
  localparam int SW = OUT_BITS + 1;
  localparam int LV = (1 << OUT_BITS) - 1;

  logic [PW-1:0]       p;
  logic [OUT_BITS-1:0] q;
  logic [3:0]          f;
  logic                bump;
  logic [SW-1:0]       sum;
  logic [OUT_BITS-1:0] nxt;

  // p = c*lv; q is the integer level, f the top 4 fraction bits.
  assign p = PW'(pix) * PW'(LV);
  assign q = OUT_BITS'(p >> IN_BITS);
  assign f = 4'(p[IN_BITS-1:0] >> (IN_BITS - 4));

  always_comb begin
    bump = 1'b0;
    sum  = '0;
    nxt  = '0;
    case (mode)
      MODE_TRUNC: nxt = OUT_BITS'(pix >> (IN_BITS - OUT_BITS));
      MODE_THRESH, MODE_DITHER: begin
        bump = (mode == MODE_THRESH) ? (f >= 4'd8) : (f > bayer_thr(row, col));
        sum  = {1'b0, q} + SW'(bump);
        // q <= lv-1 mathematically, but clamp anyway so odd widths stay safe
        nxt  = (sum > SW'(LV)) ? OUT_BITS'(LV) : sum[OUT_BITS-1:0];
      end
      default: nxt = bar_on ? OUT_BITS'(LV) : '0;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) q_out <= '0;
    else          q_out <= blank ? '0 : nxt;
  end

endmodule

// File: rtl/vga_dither_stage.sv
// Pixel stage between VGA timing generator and RGB image ROM.
// Maps (column,row) to a ROM address with integer upscale and offset,
// quantises the returned pixel per channel and delays syncs/enable so
// everything leaves aligned, MEM_LATENCY+2 cycles after the input.
//   pixel_clk, reset_n              : clock, async active-low reset
//   mode                            : quantiser mode, latched at v_sync start
//   in_h_sync, in_v_sync, in_disp_ena, column, row : from timing generator
//   mem_addr / mem_pixel            : ROM address out, {R,G,B} back
//   rgb, h_sync, v_sync, disp_ena   : aligned outputs to the VGA pins
module vga_dither_stage
  import image_pkg::*;
#(
  parameter int   IN_BITS       = 8,
  parameter int   OUT_BITS      = 1,
  parameter int   COORD_WIDTH   = 32,
  parameter int   IMAGE_WIDTH   = 116,
  parameter int   IMAGE_HEIGHT  = 78,
  parameter int   ADDRESS_WIDTH = 14,
  parameter int   SCALE_LOG2    = 0,
  parameter int   H_OFFSET      = 0,
  parameter int   V_OFFSET      = 0,
  parameter int   MEM_LATENCY   = 1,
  parameter int   BAR_SHIFT     = 8,
  parameter logic H_POL         = 1'b0,
  parameter logic V_POL         = 1'b1
) (
  input  logic                     pixel_clk,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic                     in_h_sync,
  input  logic                     in_v_sync,
  input  logic                     in_disp_ena,
  input  logic [COORD_WIDTH-1:0]   column,
  input  logic [COORD_WIDTH-1:0]   row,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [3*IN_BITS-1:0]     mem_pixel,
  output logic [3*OUT_BITS-1:0]    rgb,
  output logic                     h_sync,
  output logic                     v_sync,
  output logic                     disp_ena
);

  localparam int NUM_LANES = 3;
  // Stage A is sb_pipe[0]; pixel arrives with sb_pipe[MEM_LATENCY];
  // sb_pipe[STAGES] is aligned with the quantiser output register.
  localparam int STAGES    = MEM_LATENCY + 1;

  // ---------------- stage A: window and address ----------------
  logic [COORD_WIDTH-1:0] dx, dy, sx, sy;
  logic                   in_win;
  logic [2:0]             bar_idx;
  side_t                  side_a, side_rst;

  assign dx      = column - COORD_WIDTH'(H_OFFSET);
  assign dy      = row    - COORD_WIDTH'(V_OFFSET);
  assign sx      = dx >> SCALE_LOG2;
  assign sy      = dy >> SCALE_LOG2;
  // The >= checks keep coordinates left/above the window from wrapping in.
  assign in_win  = in_disp_ena
                 && (column >= COORD_WIDTH'(H_OFFSET))
                 && (row    >= COORD_WIDTH'(V_OFFSET))
                 && (sx < COORD_WIDTH'(IMAGE_WIDTH))
                 && (sy < COORD_WIDTH'(IMAGE_HEIGHT));
  assign bar_idx = 3'(column >> BAR_SHIFT);

  always_comb begin
    side_a        = '0;
    side_a.in_win = in_win;
    side_a.de     = in_disp_ena;
    side_a.hs     = in_h_sync;
    side_a.vs     = in_v_sync;
    side_a.row    = row[1:0];
    side_a.col    = column[1:0];
    side_a.bar    = bar_idx;
  end

  always_comb begin
    side_rst    = '0;
    side_rst.hs = sync_idle(H_POL);
    side_rst.vs = sync_idle(V_POL);
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) mem_addr <= '0;
    else          mem_addr <= in_win ? ADDRESS_WIDTH'(sy * COORD_WIDTH'(IMAGE_WIDTH) + sx) : '0;
  end

  // ---------------- side band delay line ----------------
  side_t sb_pipe [STAGES:0];

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= STAGES; k++) sb_pipe[k] <= side_rst;
    end else begin
      sb_pipe[0] <= side_a;
      for (int k = 1; k <= STAGES; k++) sb_pipe[k] <= sb_pipe[k-1];
    end
  end

  // ---------------- frame mode latch ----------------
  logic  v_prev;
  mode_e mode_q;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      v_prev <= sync_idle(V_POL);
      mode_q <= MODE_TRUNC;
    end else begin
      v_prev <= in_v_sync;
      if (in_v_sync == V_POL && v_prev != V_POL) mode_q <= mode_e'(mode);
    end
  end

  // ---------------- per-channel quantisers ----------------
  side_t                                 sb_q;
  logic                                  blank;
  logic [NUM_LANES-1:0][IN_BITS-1:0]     pix_lane;
  logic [NUM_LANES-1:0][OUT_BITS-1:0]    rgb_lane;

  assign sb_q     = sb_pipe[MEM_LATENCY];
  assign pix_lane = mem_pixel;
  // Bars ignore the image window but still respect blanking.
  assign blank    = ~(sb_q.de & (sb_q.in_win | (mode_q == MODE_BARS)));

  // Lane 2 = R, 1 = G, 0 = B, matching {R,G,B} packing and bar[2:0].
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    bayer_quantiser #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_quant (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .mode      (mode_q),
      .pix       (pix_lane[g]),
      .row       (sb_q.row),
      .col       (sb_q.col),
      .bar_on    (sb_q.bar[g]),
      .blank     (blank),
      .q_out     (rgb_lane[g])
    );
  end

  assign rgb      = rgb_lane;
  assign h_sync   = sb_pipe[STAGES].hs;
  assign v_sync   = sb_pipe[STAGES].vs;
  assign disp_ena = sb_pipe[STAGES].de;

endmodule

// File: tb/tb_vga_dither_stage.sv
// Directed bench for vga_dither_stage. Three instances share the inputs:
//   dut_a : OUT_BITS=1, MEM_LATENCY=1 (L=3)  reset, dither, mode latch
//   dut_b : OUT_BITS=2, MEM_LATENCY=3 (L=5)  alignment, mode outputs
//   dut_c : OUT_BITS=1, SCALE_LOG2=1, offsets 100/10 (L=3)  addressing
module tb_vga_dither_stage;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic [1:0]  mode      = 2'd0;
  logic        in_h_sync = 1'b1;
  logic        in_v_sync = 1'b0;
  logic        in_disp_ena = 1'b0;
  logic [31:0] column    = '0;
  logic [31:0] row       = '0;
  logic [23:0] mem_pixel = '0;

  logic [13:0] a_addr, b_addr, c_addr;
  logic [2:0]  a_rgb, c_rgb;
  logic [5:0]  b_rgb;
  logic        a_hs, a_vs, a_de, b_hs, b_vs, b_de, c_hs, c_vs, c_de;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_dither_stage #(.OUT_BITS(1), .MEM_LATENCY(1)) dut_a (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .mode(mode),
    .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .in_disp_ena(in_disp_ena),
    .column(column), .row(row), .mem_addr(a_addr), .mem_pixel(mem_pixel),
    .rgb(a_rgb), .h_sync(a_hs), .v_sync(a_vs), .disp_ena(a_de));

  vga_dither_stage #(.OUT_BITS(2), .MEM_LATENCY(3)) dut_b (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .mode(mode),
    .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .in_disp_ena(in_disp_ena),
    .column(column), .row(row), .mem_addr(b_addr), .mem_pixel(mem_pixel),
    .rgb(b_rgb), .h_sync(b_hs), .v_sync(b_vs), .disp_ena(b_de));

  vga_dither_stage #(.OUT_BITS(1), .MEM_LATENCY(1), .SCALE_LOG2(1),
                     .H_OFFSET(100), .V_OFFSET(10)) dut_c (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .mode(mode),
    .in_h_sync(in_h_sync), .in_v_sync(in_v_sync), .in_disp_ena(in_disp_ena),
    .column(column), .row(row), .mem_addr(c_addr), .mem_pixel(mem_pixel),
    .rgb(c_rgb), .h_sync(c_hs), .v_sync(c_vs), .disp_ena(c_de));

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_disp_ena = 1'b0;
    in_h_sync   = 1'b1;
    in_v_sync   = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // One-cycle v_sync pulse (active high) with mode held -> new frame mode.
  task automatic latch_mode(input logic [1:0] m);
    mode      = m;
    in_v_sync = 1'b1;
    tick();
    in_v_sync = 1'b0;
    tick();
  endtask

  // Scan columns/rows 0..3 on dut_a (L=3) and count 111 / 000 outputs.
  task automatic scan_block(output int n_set, output int n_zero);
    n_set  = 0;
    n_zero = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        in_disp_ena = 1'b1;
        column      = 32'(i % 4);
        row         = 32'(i / 4);
      end else begin
        in_disp_ena = 1'b0;
      end
      tick();
      if (i >= 2) begin
        if (a_rgb == 3'b111) n_set++;
        if (a_rgb == 3'b000) n_zero++;
      end
    end
    idle(2);
  endtask

  task automatic test_reset();
    logic [2:0] exp_rgb;
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (a_rgb !== 3'b000 || a_de !== 1'b0 || a_hs !== 1'b1 || a_vs !== 1'b0 || a_addr !== 14'd0) begin
      n_err++;
      $display("FAIL reset_state: rgb=%b de=%b hs=%b vs=%b addr=%0d, want 000 0 1 0 0",
               a_rgb, a_de, a_hs, a_vs, a_addr);
    end
    // Release with a steady in-window pixel; mode after reset is truncate.
    mem_pixel   = 24'h808080;
    column      = 32'd5;
    row         = 32'd2;
    in_disp_ena = 1'b1;
    in_h_sync   = 1'b0;
    reset_n     = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_rgb = (k == 3) ? 3'b111 : 3'b000;
      n_cmp++;
      if (a_rgb !== exp_rgb) begin
        n_err++;
        $display("FAIL release_rgb_cyc%0d: got %b want %b", k, a_rgb, exp_rgb);
      end
      if (k == 1) begin
        n_cmp++;
        if (a_addr !== 14'd237) begin
          n_err++;
          $display("FAIL release_addr: got %0d want 237", a_addr);
        end
      end
      if (k >= 2) begin
        n_cmp++;
        if (a_hs !== (k == 3 ? 1'b0 : 1'b1)) begin
          n_err++;
          $display("FAIL release_hsync_cyc%0d: got %b want %b", k, a_hs, (k == 3 ? 1'b0 : 1'b1));
        end
      end
    end
    // Drive v_sync active so outputs are all non-reset, then reset mid-line.
    in_v_sync = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (a_vs !== 1'b1 || a_de !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: vs=%b de=%b want 1 1", a_vs, a_de);
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (a_rgb !== 3'b000 || a_de !== 1'b0 || a_hs !== 1'b1 || a_vs !== 1'b0 || a_addr !== 14'd0) begin
      n_err++;
      $display("FAIL async_reset: rgb=%b de=%b hs=%b vs=%b addr=%0d, want 000 0 1 0 0",
               a_rgb, a_de, a_hs, a_vs, a_addr);
    end
    idle(1);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_alignment();
    logic       exp_hs;
    logic [5:0] exp_rgb;
    latch_mode(2'd0);
    mem_pixel = 24'hC0C0C0;
    idle(6);
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) begin
        in_h_sync   = 1'b0;
        in_disp_ena = 1'b1;
        column      = 32'd0;
        row         = 32'd0;
      end else begin
        in_h_sync   = 1'b1;
        in_disp_ena = 1'b0;
      end
      tick();
      exp_hs  = (k == 5) ? 1'b0 : 1'b1;
      exp_rgb = (k == 5) ? 6'b111111 : 6'b000000;
      n_cmp++;
      if (b_hs !== exp_hs || b_rgb !== exp_rgb) begin
        n_err++;
        $display("FAIL align_cyc%0d: hs=%b rgb=%b want hs=%b rgb=%b", k, b_hs, b_rgb, exp_hs, exp_rgb);
      end
    end
    idle(2);
  endtask

  task automatic test_addressing();
    // column, row, expected address, expected rgb
    int         vc [7] = '{101, 102, 332, 99,  100, 331, 100};
    int         vr [7] = '{11,  13,  10,  11,  9,   10,  10};
    int         va [7] = '{0,   117, 0,   0,   0,   115, 0};
    logic [2:0] vo [7] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111};
    latch_mode(2'd0);
    mem_pixel = 24'h808080;
    for (int i = 0; i < 7; i++) begin
      column      = 32'(vc[i]);
      row         = 32'(vr[i]);
      in_disp_ena = 1'b1;
      tick();
      n_cmp++;
      if (c_addr !== 14'(va[i])) begin
        n_err++;
        $display("FAIL addr_c%0d_r%0d: got %0d want %0d", vc[i], vr[i], c_addr, va[i]);
      end
      tick(); tick();
      n_cmp++;
      if (c_rgb !== vo[i]) begin
        n_err++;
        $display("FAIL win_rgb_c%0d_r%0d: got %b want %b", vc[i], vr[i], c_rgb, vo[i]);
      end
    end
    idle(3);
  endtask

  task automatic test_dither();
    logic [23:0] pix [3] = '{24'h808080, 24'h000000, 24'hFFFFFF};
    int          want [3] = '{8, 0, 15};
    int          ns, nz;
    latch_mode(2'd2);
    for (int i = 0; i < 3; i++) begin
      mem_pixel = pix[i];
      scan_block(ns, nz);
      n_cmp++;
      if (ns !== want[i] || ns + nz !== 16) begin
        n_err++;
        $display("FAIL dither_%h: set=%0d zero=%0d want set=%0d zero=%0d",
                 pix[i], ns, nz, want[i], 16 - want[i]);
      end
    end
  endtask

  task automatic test_mode_latch();
    int ns, nz;
    latch_mode(2'd2);
    mem_pixel = 24'h808080;
    mode      = 2'd0;          // mid-frame change, no v_sync edge yet
    scan_block(ns, nz);
    n_cmp++;
    if (ns !== 8 || nz !== 8) begin
      n_err++;
      $display("FAIL latch_midframe: set=%0d zero=%0d want 8 8", ns, nz);
    end
    latch_mode(2'd0);
    scan_block(ns, nz);
    n_cmp++;
    if (ns !== 16) begin
      n_err++;
      $display("FAIL latch_nextframe: set=%0d want 16", ns);
    end
  endtask

  task automatic test_modes();
    // mode, column, row, disp_ena, expected dut_b rgb
    logic [1:0] vm [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    int         vc [7] = '{0, 0, 0, 1, 'h300, 'h500, 'h300};
    logic       vd [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] vo [7] = '{6'b111111, 6'b101010, 6'b111111, 6'b101010,
                           6'b001111, 6'b110011, 6'b000000};
    mem_pixel = 24'hC0C0C0;
    for (int i = 0; i < 7; i++) begin
      latch_mode(vm[i]);
      column      = 32'(vc[i]);
      row         = 32'd0;
      in_disp_ena = vd[i];
      for (int k = 0; k < 5; k++) tick();
      n_cmp++;
      if (b_rgb !== vo[i]) begin
        n_err++;
        $display("FAIL mode%0d_col%0h_de%0d: got %b want %b", vm[i], vc[i], vd[i], b_rgb, vo[i]);
      end
      if (i == 4) begin
        // row 0 is above dut_c's window; bars still show
        n_cmp++;
        if (c_rgb !== 3'b011) begin
          n_err++;
          $display("FAIL bars_ignore_window: got %b want 011", c_rgb);
        end
      end
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_alignment();
    test_addressing();
    test_dither();
    test_mode_latch();
    test_modes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
